// File: rtl/ip_dst_extract_pkg.sv
// Shared constants, slice offsets and types for destination-IP extraction.
// Offsets are bit positions within a 256-bit stream word, byte 0 at the MSBs.
package ip_dst_extract_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

    localparam int ETHERTYPE_LSB = 144;  // word 1, tdata[159:144]
    localparam int VER_IHL_LSB   = 136;  // word 1, tdata[143:136]
    localparam int DST_HI_LSB    = 0;    // word 1, tdata[15:0]
    localparam int DST_LO_LSB    = 240;  // word 2, tdata[255:240]

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_HAVE_HI = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] dst_ip;
        logic        is_ipv4;
    } ip_entry_t;

    function automatic logic is_plain_ipv4(input logic [255:0] w);
        return (w[ETHERTYPE_LSB +: 16] == ETHERTYPE_IPV4) &&
               (w[VER_IHL_LSB +: 8] == IPV4_VER_IHL);
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// First-word-fall-through FIFO; a write is visible at the head the next cycle.
// A write into a full FIFO without a same-cycle read is dropped and flagged sticky.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 33,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             nearly_full,
    output logic             overflow
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    typedef logic [MAX_DEPTH_BITS:0]   cnt_t;
    typedef logic [MAX_DEPTH_BITS-1:0] ptr_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_NF   = cnt_t'(DEPTH - 1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam ptr_t PTR_ONE  = ptr_t'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic overflow_q, overflow_d;
    logic pop, push;

    assign empty       = (count_q == '0);
    assign nearly_full = (count_q >= CNT_NF);
    assign overflow    = overflow_q;
    assign dout        = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign pop  = rd_en && !empty;
    assign push = wr_en && ((count_q != CNT_FULL) || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (wr_en && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/ip_dst_extract.sv
// Captures the IPv4 destination address split across packet words 1 and 2 and queues one result per packet.
// Result visible the cycle after the strobe; the stream is never stalled, results overflowing the FIFO are dropped.
module ip_dst_extract
    import ip_dst_extract_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int FIFO_DEPTH_BITS     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] tdata,
    input  logic                           valid,
    input  logic                           tlast,
    input  logic                           word_IP_DST_HI,
    input  logic                           word_IP_DST_LO,
    output logic [31:0]                    dst_ip_dout,
    output logic                           is_ipv4_dout,
    input  logic                           dst_ip_rd_en,
    output logic                           dst_ip_empty,
    output logic                           dst_ip_nearly_full,
    output logic                           overflow
);
    state_t      state_q, state_d;
    logic [15:0] ip_hi_q, ip_hi_d;
    logic        v4_q, v4_d;
    logic        push;
    ip_entry_t   push_entry;
    ip_entry_t   head;
    logic        unused_tdata;

    // Only a few byte lanes matter; the rest of the word is intentionally ignored.
    assign unused_tdata = ^tdata;

    always_comb begin
        state_d    = state_q;
        ip_hi_d    = ip_hi_q;
        v4_d       = v4_q;
        push       = 1'b0;
        push_entry = '0;
        case (state_q)
            ST_IDLE: begin
                if (valid && word_IP_DST_HI) begin
                    if (tlast) begin
                        // Packet ends before the low half arrives: emit a null entry to keep one result per packet.
                        push = 1'b1;
                    end else begin
                        ip_hi_d = tdata[DST_HI_LSB +: 16];
                        v4_d    = is_plain_ipv4(tdata);
                        state_d = ST_HAVE_HI;
                    end
                end
            end
            ST_HAVE_HI: begin
                if (valid && word_IP_DST_LO) begin
                    push               = 1'b1;
                    push_entry.dst_ip  = {ip_hi_q, tdata[DST_LO_LSB +: 16]};
                    push_entry.is_ipv4 = v4_q;
                    state_d            = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ip_hi_q <= '0;
            v4_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_hi_q <= ip_hi_d;
            v4_q    <= v4_d;
        end
    end

    fallthrough_small_fifo #(
        .WIDTH          ($bits(ip_entry_t)),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_result_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         (push_entry),
        .wr_en       (push),
        .rd_en       (dst_ip_rd_en),
        .dout        (head),
        .empty       (dst_ip_empty),
        .nearly_full (dst_ip_nearly_full),
        .overflow    (overflow)
    );

    assign dst_ip_dout  = head.dst_ip;
    assign is_ipv4_dout = head.is_ipv4;

endmodule
